// File: rtl/cram_access_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cram_access_sched_if
// Description : Bus bundle between the CRAM access scheduler and its
//               neighbours.
//               Upstream side: picture/blanking flag, greyscale enable,
//               render palette index and the CPU register-7 request port.
//               Downstream side: CRAM index, write strobe, write data,
//               read data, and the render colour output.
//               slave  : the scheduler itself
//               master : the environment (pixel mux, register file, CRAM)
// Ports       : n_PICTURE, BnW, pix_pal           render-side inputs
//               cpu_req/we/addr/wdata              CPU request inputs
//               cpu_busy/ack/rdata/drop            CPU status outputs
//               PAL, cram_we, cram_wdata           CRAM drive outputs
//               cram_rdata                         CRAM read data input
//               color_out, collide                 render outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface cram_access_sched_if #(
    parameter int IDX_W = 5,
    parameter int COL_W = 6
);
    logic             n_PICTURE;
    logic             BnW;
    logic [IDX_W-1:0] pix_pal;
    logic             cpu_req;
    logic             cpu_we;
    logic [IDX_W-1:0] cpu_addr;
    logic [COL_W-1:0] cpu_wdata;
    logic             cpu_busy;
    logic             cpu_ack;
    logic [COL_W-1:0] cpu_rdata;
    logic             cpu_drop;
    logic [IDX_W-1:0] PAL;
    logic             cram_we;
    logic [COL_W-1:0] cram_wdata;
    logic [COL_W-1:0] cram_rdata;
    logic [COL_W-1:0] color_out;
    logic             collide;

    modport slave (
        input  n_PICTURE, BnW, pix_pal,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cram_rdata,
        output cpu_busy, cpu_ack, cpu_rdata, cpu_drop,
        output PAL, cram_we, cram_wdata,
        output color_out, collide
    );

    modport master (
        output n_PICTURE, BnW, pix_pal,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cram_rdata,
        input  cpu_busy, cpu_ack, cpu_rdata, cpu_drop,
        input  PAL, cram_we, cram_wdata,
        input  color_out, collide
    );
endinterface
`default_nettype wire

// File: rtl/cram_access_sched.sv
`default_nettype none
// ============================================================================
// Module      : cram_access_sched
// Description : Shares the single palette-RAM port between the render pixel
//               path (one lookup per PCLK) and CPU palette reads/writes.
//               Render has priority: a CPU access waits in a pending register
//               until n_PICTURE=1, then borrows two lookup slots (address
//               issue + hold) before acknowledging. Palette mirroring is
//               applied to both index sources; greyscale masking is applied
//               to the render colour.
// Ports       : PCLK   - clock, rising edge
//               n_RES  - synchronous active-low reset
//               bus    - cram_access_sched_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module cram_access_sched #(
    parameter int IDX_W = 5,
    parameter int COL_W = 6
) (
    input  logic               PCLK,
    input  logic               n_RES,
    cram_access_sched_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        CPU_RD = 3'd2,
        CPU_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_pend_we;
    logic [IDX_W-1:0] r_pend_addr;
    logic [COL_W-1:0] r_pend_data;

    // Per-slot tags travelling alongside the 2-cycle CRAM lookup:
    // disp = slot was taken by the CPU, npic = n_PICTURE when slot issued.
    logic             r_disp_d1;
    logic             r_disp_d2;
    logic             r_npic_d1;
    logic             r_npic_d2;

    logic             w_grant;
    logic             w_in_cpu;
    logic             w_capture;

    // Sprite/backdrop mirror: entries whose low two bits are zero fold the
    // top index bit away (0x10/14/18/1C alias 0x00/04/08/0C).
    function automatic logic [IDX_W-1:0] mirror(input logic [IDX_W-1:0] a);
        logic [IDX_W-1:0] m;
        m = a;
        if (a[1:0] == 2'b00) m[IDX_W-1] = 1'b0;
        return m;
    endfunction

    // Greyscale keeps only the luminance bits of the entry.
    function automatic logic [COL_W-1:0] grey(input logic [COL_W-1:0] d,
                                              input logic             bw);
        return bw ? {d[COL_W-1 -: 2], {(COL_W-2){1'b0}}} : d;
    endfunction

    assign w_grant   = (r_state == PEND) && bus.n_PICTURE;
    assign w_in_cpu  = (r_state == CPU_RD) || (r_state == CPU_WR);
    // busy is high exactly while the FSM is outside IDLE
    assign w_capture = bus.cpu_req && (r_state == IDLE);

    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            r_state        <= IDLE;
            r_pend_we      <= 1'b0;
            r_pend_addr    <= '0;
            r_pend_data    <= '0;
            r_disp_d1      <= 1'b0;
            r_disp_d2      <= 1'b0;
            r_npic_d1      <= 1'b0;
            r_npic_d2      <= 1'b0;
            bus.PAL        <= '0;
            bus.cram_we    <= 1'b0;
            bus.cram_wdata <= '0;
            bus.color_out  <= '0;
            bus.collide    <= 1'b0;
            bus.cpu_busy   <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_drop   <= 1'b0;
        end else begin
            bus.cram_we <= 1'b0;
            bus.cpu_ack <= 1'b0;

            // CRAM address: the CPU address is issued on the grant edge and
            // held through the CPU_* cycle so its read data lands at the
            // DONE edge; every other edge issues a render lookup.
            if (w_grant) begin
                bus.PAL     <= r_pend_addr;
                bus.cram_we <= r_pend_we;
                if (r_pend_we) bus.cram_wdata <= r_pend_data;
            end else if (!w_in_cpu) begin
                bus.PAL <= mirror(bus.pix_pal);
            end

            r_disp_d1 <= w_grant || w_in_cpu;
            r_npic_d1 <= bus.n_PICTURE;
            r_disp_d2 <= r_disp_d1;
            r_npic_d2 <= r_npic_d1;

            // Render result for the slot issued two edges ago; a CPU-owned
            // slot leaves the colour unchanged and flags a collision if it
            // fell inside the visible picture.
            if (!r_disp_d2) begin
                bus.color_out <= grey(bus.cram_rdata, bus.BnW);
            end else if (!r_npic_d2) begin
                bus.collide <= 1'b1;
            end

            if (bus.cpu_req && bus.cpu_busy) bus.cpu_drop <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_pend_we    <= bus.cpu_we;
                        r_pend_addr  <= mirror(bus.cpu_addr);
                        r_pend_data  <= bus.cpu_wdata;
                        bus.cpu_busy <= 1'b1;
                        r_state      <= PEND;
                    end
                end
                PEND: begin
                    if (bus.n_PICTURE) r_state <= r_pend_we ? CPU_WR : CPU_RD;
                end
                CPU_RD, CPU_WR: begin
                    r_state <= DONE;
                end
                DONE: begin
                    bus.cpu_ack  <= 1'b1;
                    bus.cpu_busy <= 1'b0;
                    if (!r_pend_we) bus.cpu_rdata <= bus.cram_rdata;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cram_access_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cram_access_sched
// Description : Testbench for cram_access_sched with a behavioural CRAM and
//               a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cram_access_sched;
    localparam int IDX_W = 5;
    localparam int COL_W = 6;

    logic PCLK  = 1'b0;
    logic n_RES = 1'b0;
    always #5 PCLK = ~PCLK;

    cram_access_sched_if #(.IDX_W(IDX_W), .COL_W(COL_W)) bus ();

    cram_access_sched #(.IDX_W(IDX_W), .COL_W(COL_W)) dut (
        .PCLK  (PCLK),
        .n_RES (n_RES),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [COL_W-1:0] init_val(input int i);
        if (i == 10) return 6'h2A;
        return 6'((i * 37 + 11) % 64);
    endfunction

    function automatic logic [IDX_W-1:0] tb_mirror(input logic [IDX_W-1:0] a);
        return ((a & 5'd3) == 5'd0) ? (a & 5'd15) : a;
    endfunction

    function automatic logic [COL_W-1:0] tb_grey(input logic [COL_W-1:0] d, input logic b);
        return b ? (d & 6'h30) : d;
    endfunction

    function automatic logic [3:0] ix(input int c);
        return 4'(c & 15);
    endfunction

    // ---------------- behavioural CRAM (registered read) ----------------
    logic [COL_W-1:0] cram [0:31];
    initial begin
        logic [COL_W-1:0] rd;
        for (int i = 0; i < 32; i++) cram[i] = init_val(i);
        forever begin
            @(posedge PCLK);
            rd = cram[bus.PAL];
            if (bus.cram_we) cram[bus.PAL] = bus.cram_wdata;
            bus.cram_rdata <= rd;
        end
    end

    // ---------------- reference model ----------------
    // Ring histories indexed by edge number: expected CRAM address/strobe,
    // whether the slot belongs to the CPU, n_PICTURE at the slot, reset, and
    // the entry the CRAM returns for that slot.
    logic [COL_W-1:0] ref_mem [0:31];
    logic [IDX_W-1:0] pal_h  [0:15];
    logic             we_h   [0:15];
    logic [COL_W-1:0] wd_h   [0:15];
    logic             disp_h [0:15];
    logic             npic_h [0:15];
    logic             rst_h  [0:15];
    logic [COL_W-1:0] rd_h   [0:15];

    logic             m_busy, m_ack, m_drop, m_collide, m_we;
    logic [IDX_W-1:0] m_pal;
    logic [COL_W-1:0] m_wdata, m_color, m_rdata;
    logic             txn, t_we;
    int               t_grant;
    logic [IDX_W-1:0] t_addr;
    logic [COL_W-1:0] t_data;

    initial begin
        int c;
        logic busy_before, slot_disp;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 16; i++) begin
            pal_h[i] = '0; we_h[i] = 1'b0; wd_h[i] = '0; disp_h[i] = 1'b0;
            npic_h[i] = 1'b1; rst_h[i] = 1'b1; rd_h[i] = '0;
        end
        m_busy = 0; m_ack = 0; m_drop = 0; m_collide = 0; m_we = 0;
        m_pal = '0; m_wdata = '0; m_color = '0; m_rdata = '0;
        txn = 0; t_we = 0; t_grant = -1; t_addr = '0; t_data = '0;
        forever begin
            @(posedge PCLK);
            #1;
            c = cyc;
            if (c > 0) begin
                rd_h[ix(c-1)] = ref_mem[pal_h[ix(c-1)]];
                if (we_h[ix(c-1)]) ref_mem[pal_h[ix(c-1)]] = wd_h[ix(c-1)];
            end
            m_ack = 1'b0;
            if (!n_RES) begin
                rst_h[ix(c)] = 1'b1; disp_h[ix(c)] = 1'b0; npic_h[ix(c)] = 1'b1;
                txn = 0; m_busy = 0; m_drop = 0; m_collide = 0;
                m_pal = '0; m_we = 0; m_wdata = '0; m_color = '0; m_rdata = '0;
            end else begin
                rst_h[ix(c)]  = 1'b0;
                npic_h[ix(c)] = bus.n_PICTURE;
                disp_h[ix(c)] = 1'b0;
                slot_disp = disp_h[ix(c-2)] && !rst_h[ix(c-1)];
                if (!slot_disp) m_color = tb_grey(rd_h[ix(c-2)], bus.BnW);
                else if (!npic_h[ix(c-2)]) m_collide = 1'b1;

                busy_before = m_busy;
                m_pal = tb_mirror(bus.pix_pal);
                m_we  = 1'b0;
                if (txn) begin
                    if (t_grant < 0) begin
                        if (bus.n_PICTURE) begin
                            t_grant = c; disp_h[ix(c)] = 1'b1;
                            m_pal = t_addr; m_we = t_we;
                            if (t_we) m_wdata = t_data;
                        end
                    end else if (c == t_grant + 1) begin
                        disp_h[ix(c)] = 1'b1; m_pal = t_addr;
                    end else begin
                        m_ack = 1'b1;
                        if (!t_we) m_rdata = rd_h[ix(t_grant)];
                        txn = 0;
                    end
                end
                if (bus.cpu_req) begin
                    if (busy_before) m_drop = 1'b1;
                    else begin
                        txn = 1; t_grant = -1; t_we = bus.cpu_we;
                        t_addr = tb_mirror(bus.cpu_addr); t_data = bus.cpu_wdata;
                    end
                end
                m_busy = txn;
            end
            pal_h[ix(c)] = m_pal; we_h[ix(c)] = m_we; wd_h[ix(c)] = m_wdata;

            check("pal",        32'(bus.PAL),        32'(m_pal));
            check("cram_we",    32'(bus.cram_we),    32'(m_we));
            check("cram_wdata", 32'(bus.cram_wdata), 32'(m_wdata));
            check("color_out",  32'(bus.color_out),  32'(m_color));
            check("collide",    32'(bus.collide),    32'(m_collide));
            check("cpu_busy",   32'(bus.cpu_busy),   32'(m_busy));
            check("cpu_ack",    32'(bus.cpu_ack),    32'(m_ack));
            check("cpu_rdata",  32'(bus.cpu_rdata),  32'(m_rdata));
            check("cpu_drop",   32'(bus.cpu_drop),   32'(m_drop));
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic rand_inputs();
        bus.n_PICTURE = 1'($urandom);
        bus.BnW       = 1'($urandom);
        bus.pix_pal   = 5'($urandom);
        bus.cpu_req   = 1'($urandom);
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 5'($urandom);
        bus.cpu_wdata = 6'($urandom);
    endtask

    task automatic wait_ack(input int t0, input string tag);
        int n;
        n = 0;
        while (!bus.cpu_ack && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(cyc - t0), 32'd3);
    endtask

    initial begin
        int t0;
        logic [COL_W-1:0] hold;

        // reset with random inputs
        n_RES = 1'b0;
        rand_inputs();
        step();
        rand_inputs();
        step();
        check("rst_pal",   32'(bus.PAL),       32'd0);
        check("rst_we",    32'(bus.cram_we),   32'd0);
        check("rst_busy",  32'(bus.cpu_busy),  32'd0);
        check("rst_drop",  32'(bus.cpu_drop),  32'd0);
        check("rst_color", 32'(bus.color_out), 32'd0);

        // render path with mirroring
        n_RES = 1'b1; bus.cpu_req = 1'b0; bus.n_PICTURE = 1'b0; bus.BnW = 1'b0;
        bus.pix_pal = 5'h01; step();
        check("mir_01", 32'(bus.PAL), 32'h01); bus.pix_pal = 5'h13; step();
        check("mir_13", 32'(bus.PAL), 32'h13); bus.pix_pal = 5'h10; step();
        check("mir_10", 32'(bus.PAL), 32'h00); bus.pix_pal = 5'h1C; step();
        check("mir_1C", 32'(bus.PAL), 32'h0C);
        bus.pix_pal = 5'h0A; bus.BnW = 1'b1;
        step(); step(); step();
        check("grey_2A", 32'(bus.color_out), 32'h20);
        bus.BnW = 1'b0;

        // CPU write during blanking
        bus.n_PICTURE = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'h14; bus.cpu_wdata = 6'h3F;
        step(); t0 = cyc; bus.cpu_req = 1'b0;
        step();
        check("wr_we",    32'(bus.cram_we),    32'd1);
        check("wr_pal",   32'(bus.PAL),        32'h04);
        check("wr_wdata", 32'(bus.cram_wdata), 32'h3F);
        step();
        check("wr_we_off", 32'(bus.cram_we), 32'd0);
        wait_ack(t0, "wr_ack_lat");

        // CPU read deferred by visible picture
        step();
        bus.n_PICTURE = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'h05;
        step(); bus.cpu_req = 1'b0;
        repeat (100) step();
        check("rd_defer_busy", 32'(bus.cpu_busy), 32'd1);
        bus.n_PICTURE = 1'b1; t0 = cyc;
        wait_ack(t0, "rd_ack_lat");
        check("rd_data", 32'(bus.cpu_rdata), 32'(init_val(5)));

        // overlap: drop while busy, accept in the ack cycle
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'h02; bus.cpu_wdata = 6'h11;
        step();
        bus.cpu_addr = 5'h03;
        step(); bus.cpu_req = 1'b0;
        check("drop_set", 32'(bus.cpu_drop), 32'd1);
        t0 = 0;
        while (!bus.cpu_ack && t0 < 50) begin step(); t0++; end
        check("ack_seen", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'h0A;
        step(); t0 = cyc; bus.cpu_req = 1'b0;
        wait_ack(t0, "done_req_lat");
        check("done_req_data", 32'(bus.cpu_rdata), 32'h2A);

        // collision: n_PICTURE falls right after the grant
        step();
        check("collide_pre", 32'(bus.collide), 32'd0);
        bus.n_PICTURE = 1'b0; bus.pix_pal = 5'h0A;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'h07; bus.cpu_wdata = 6'h05;
        step(); bus.cpu_req = 1'b0;
        step(); step();
        bus.n_PICTURE = 1'b1;
        step();
        bus.n_PICTURE = 1'b0;
        step();
        hold = bus.color_out;
        step();
        check("coll_ack",   32'(bus.cpu_ack),   32'd1);
        check("coll_hold1", 32'(bus.color_out), 32'(hold));
        step();
        check("coll_hold2", 32'(bus.color_out), 32'(hold));
        check("coll_flag",  32'(bus.collide),   32'd1);

        // reset with a grant imminent
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'h09; bus.cpu_wdata = 6'h22;
        step(); bus.cpu_req = 1'b0;
        step();
        bus.n_PICTURE = 1'b1; n_RES = 1'b0;
        step();
        check("rmid_we",   32'(bus.cram_we),  32'd0);
        check("rmid_busy", 32'(bus.cpu_busy), 32'd0);
        n_RES = 1'b1;
        step(); step();
        check("rmid_we2",   32'(bus.cram_we),  32'd0);
        check("rmid_busy2", 32'(bus.cpu_busy), 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            n_RES = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 7) == 0) bus.n_PICTURE = ~bus.n_PICTURE;
            if ($urandom_range(0, 15) == 0) bus.BnW = ~bus.BnW;
            bus.pix_pal   = 5'($urandom);
            bus.cpu_req   = ($urandom_range(0, 3) == 0);
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = 5'($urandom);
            bus.cpu_wdata = 6'($urandom);
            step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cram_access_sched.md
Name: cram_access_sched

Overview:
- Schedules the single palette-RAM (CRAM) port between two requesters: the render pixel path (palette index every PCLK) and CPU register-7 palette reads/writes.
- Applies palette mirroring, runs a fixed-latency render lookup pipeline and applies greyscale masking.
- Sits between the pixel multiplexer and register interface upstream, and the CRAM decoder/array downstream.
- Render path has priority. CPU accesses are held pending until a blanking slot opens.

Parameters:
- IDX_W, 5, palette index width
- COL_W, 6, palette entry width

Ports:
- PCLK  in  1  clock; all state updates on rising edge
- n_RES  in  1  reset, synchronous, active-low
- n_PICTURE  in  1  0 = visible picture; render owns CRAM
- BnW  in  1  greyscale enable
- pix_pal  in  IDX_W  render palette index, sampled every cycle
- cpu_req  in  1  single-cycle access request pulse
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  in  IDX_W  CPU palette index; qualified by cpu_req
- cpu_wdata  in  COL_W  write data; qualified by cpu_req
- cpu_busy  out  1  request pending or in flight
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  COL_W  read result; valid from cpu_ack onward
- cpu_drop  out  1  sticky: a request arrived while busy
- PAL  out  IDX_W  CRAM index, registered
- cram_we  out  1  CRAM write strobe, registered
- cram_wdata  out  COL_W  CRAM write data
- cram_rdata  in  COL_W  CRAM read data; valid the cycle after PAL
- color_out  out  COL_W  render colour, registered
- collide  out  1  sticky: a render lookup was displaced by a CPU slot

Behaviour:
- Reset when n_RES=0 at an edge:
  - State is IDLE. The pending register is cleared.
  - PAL=0, cram_we=0, cram_wdata=0, color_out=0, cpu_rdata=0.
  - cpu_busy, cpu_ack, cpu_drop and collide are all 0.
  - A request in flight is abandoned. No write is issued.
- Mirroring function m(a): if a[1:0]==0, return {1'b0, a[3:0]}; otherwise return a. Indices 0x10/0x14/0x18/0x1C map to 0x00/0x04/0x08/0x0C.
- Request capture:
  - cpu_req=1 while cpu_busy=0 latches we/m(addr)/wdata into the pending register and sets cpu_busy on the next cycle.
  - cpu_req=1 while cpu_busy=1 is ignored and sets cpu_drop. cpu_drop clears only on reset.
- FSM states: IDLE, PEND, CPU_RD, CPU_WR, DONE.
  - IDLE -> PEND on capture.
  - PEND -> CPU_RD or CPU_WR at the first edge where n_PICTURE=1. PEND is held indefinitely while n_PICTURE=0.
  - CPU_WR, one cycle: PAL = pending addr, cram_we=1, cram_wdata = pending data. Then -> DONE.
  - CPU_RD, one cycle: PAL = pending addr, cram_we=0. Then -> DONE. At the DONE edge, cpu_rdata <= cram_rdata.
  - DONE: cpu_ack=1 for exactly one cycle. cpu_busy drops in the same cycle. Then -> IDLE.
  - A new cpu_req during DONE is accepted, since busy is 0 in that cycle.
- Grant latency: cpu_ack asserts 3 cycles after the request edge, given n_PICTURE=1 throughout.
- Render pipeline, fixed 2-cycle latency:
  - In any cycle not in CPU_RD or CPU_WR: PAL <= m(pix_pal) at edge k, CRAM returns data during k+1, color_out <= f(cram_rdata) at edge k+2.
  - f(d) = BnW ? {d[5:4], 4'b0} : d. BnW is sampled at edge k+2.
  - Lookup slots consumed by a CPU access hold color_out at its previous value.
  - If such a displaced slot occurs while the delayed n_PICTURE (sampled at k) was 0, collide is set.
  - Render lookups also run during blanking; upstream supplies the backdrop index there.
- Simultaneous events:
  - n_PICTURE falling in the same edge as the PEND->CPU_* grant: the grant wins, the access completes, and collide sets on the displaced render slot.
  - Reset overrides all other events.
- cram_we is never asserted outside CPU_WR.

Test Plan:
- Reset: hold n_RES=0 for 2 cycles with random inputs -> all outputs 0, state IDLE, no cram_we.
- Render path: n_PICTURE=0, pix_pal = 0x01, 0x13, 0x10, 0x1C on consecutive cycles -> PAL = 0x01, 0x13, 0x00, 0x0C; color_out equals CRAM contents 2 cycles later. With BnW=1 and entry 0x2A -> color_out = 0x20.
- CPU write in blank: n_PICTURE=1, req we=1 addr=0x14 data=0x3F -> cram_we high one cycle with PAL=0x04 and cram_wdata=0x3F; cpu_ack 3 cycles after the request.
- CPU read deferred: n_PICTURE=0, req read addr 0x05 -> cpu_busy=1 and no CRAM access for 100 cycles. Raise n_PICTURE -> cpu_ack 3 cycles later; cpu_rdata = entry 0x05.
- Overlap: a second cpu_req while busy -> dropped and cpu_drop=1. A request in the DONE cycle -> accepted, and its ack follows 3 cycles later.
- Collision / reset mid-op: grant on the same edge n_PICTURE falls -> access completes, collide=1, color_out held for that slot. Assert n_RES during CPU_WR-1 (PEND with grant imminent) -> no cram_we issued, cpu_busy=0.
